// File: rtl/handshake_const_match_pkg.sv
// rtl/handshake_const_match_pkg.sv - shared token widths, constant literal and skid occupancy states
package handshake_const_match_pkg;

  localparam int HS_DATA_WIDTH     = 32;
  localparam int HS_CNT_WIDTH      = 8;
  localparam int HS_CTRL_PAYLOAD_W = 1;
  localparam int HS_SKID_DEPTH     = 2;

  // The producing constant block imports this same literal so both ends agree.
  localparam logic [16:0] HS_CONST_VALUE = 17'h0FA9A;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/handshake_const_match_if.sv
// rtl/handshake_const_match_if.sv - data-in / control-out token channel bundle
interface handshake_const_match_if
  import handshake_const_match_pkg::*;
#(
  parameter int DATA_WIDTH = HS_DATA_WIDTH,
  parameter int CNT_WIDTH  = HS_CNT_WIDTH
);

  logic [DATA_WIDTH-1:0] ins;
  logic                  ins_valid;
  logic                  ins_ready;
  logic                  ctrl_valid;
  logic                  ctrl_ready;
  logic                  match;
  logic [CNT_WIDTH-1:0]  mismatch_cnt;
  logic                  err_sticky;

  modport master (
    output ins, ins_valid, ctrl_ready,
    input  ins_ready, ctrl_valid, match, mismatch_cnt, err_sticky
  );

  modport slave (
    input  ins, ins_valid, ctrl_ready,
    output ins_ready, ctrl_valid, match, mismatch_cnt, err_sticky
  );

endinterface

// File: rtl/handshake_const_match_skid2.sv
// rtl/handshake_const_match_skid2.sv - 2-slot skid FIFO of 1-bit results, ready from registered occupancy
module handshake_skid2
  import handshake_const_match_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push_data,
  input  logic i_push_valid,
  output logic o_push_ready,
  output logic o_pop_valid,
  input  logic i_pop_ready,
  output logic o_pop_data
);

  occ_e r_occ;
  occ_e w_occ_nxt;
  logic r_head;
  logic r_tail;
  logic w_head_nxt;
  logic w_tail_nxt;
  logic w_push;
  logic w_pop;

  assign o_push_ready = (r_occ != OCC_FULL);
  assign o_pop_valid  = (r_occ != OCC_EMPTY);
  assign o_pop_data   = r_head;
  assign w_push       = i_push_valid & o_push_ready;
  assign w_pop        = o_pop_valid & i_pop_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_occ  <= OCC_EMPTY;
      r_head <= 1'b0;
      r_tail <= 1'b0;
    end else begin
      r_occ  <= w_occ_nxt;
      r_head <= w_head_nxt;
      r_tail <= w_tail_nxt;
    end
  end

  always_comb begin
    w_occ_nxt  = r_occ;
    w_head_nxt = r_head;
    w_tail_nxt = r_tail;
    case (r_occ)
      OCC_EMPTY: begin
        if (w_push) begin
          w_occ_nxt  = OCC_ONE;
          w_head_nxt = i_push_data;
        end
      end
      OCC_ONE: begin
        case ({w_push, w_pop})
          2'b10: begin
            w_occ_nxt  = OCC_FULL;
            w_tail_nxt = i_push_data;
          end
          2'b01:   w_occ_nxt  = OCC_EMPTY;
          // Head leaves and the new result takes its place on the same edge.
          2'b11:   w_head_nxt = i_push_data;
          default: w_occ_nxt  = r_occ;
        endcase
      end
      OCC_FULL: begin
        if (w_pop) begin
          w_occ_nxt  = OCC_ONE;
          w_head_nxt = r_tail;
        end
      end
      default: w_occ_nxt = OCC_EMPTY;
    endcase
  end

endmodule

// File: rtl/handshake_const_match.sv
// rtl/handshake_const_match.sv - compares each accepted word to a constant and returns a control token with match flag
module handshake_const_match
  import handshake_const_match_pkg::*;
#(
  parameter int          DATA_WIDTH  = HS_DATA_WIDTH,
  parameter logic [16:0] CONST_VALUE = HS_CONST_VALUE,
  parameter int          CNT_WIDTH   = HS_CNT_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  handshake_const_match_if.slave  bus
);

  // Zero-extends or truncates the literal to the data word width.
  localparam logic [DATA_WIDTH-1:0] CONST_WORD = DATA_WIDTH'(CONST_VALUE);

  logic                 w_match_in;
  logic                 w_ins_ready;
  logic                 w_push;
  logic [CNT_WIDTH-1:0] r_mismatch_cnt;
  logic                 r_err_sticky;

  assign w_match_in = (bus.ins == CONST_WORD);
  assign w_push     = bus.ins_valid & w_ins_ready;

  handshake_skid2 u_skid (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push_data  (w_match_in),
    .i_push_valid (bus.ins_valid),
    .o_push_ready (w_ins_ready),
    .o_pop_valid  (bus.ctrl_valid),
    .i_pop_ready  (bus.ctrl_ready),
    .o_pop_data   (bus.match)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mismatch_cnt <= '0;
      r_err_sticky   <= 1'b0;
    end else if (w_push && !w_match_in) begin
      r_err_sticky <= 1'b1;
      if (r_mismatch_cnt != {CNT_WIDTH{1'b1}}) begin
        r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
      end
    end
  end

  assign bus.ins_ready    = w_ins_ready;
  assign bus.mismatch_cnt = r_mismatch_cnt;
  assign bus.err_sticky   = r_err_sticky;

endmodule
